// File: rtl/fp_rsp_collector_if.sv
// Response handshake bundle between NUM_CORES FP cores and the merged FPU
// writeback stream; the collector sits on the slave side.
interface fp_rsp_collector_if #(
  parameter int NUM_CORES = 4,
  parameter int TAGW      = 1,
  parameter int LANES     = 1
);
  localparam int CW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

  logic [NUM_CORES-1:0]          valid_in;
  logic [NUM_CORES-1:0]          ready_in;
  logic [NUM_CORES*TAGW-1:0]     tag_in;
  logic [NUM_CORES*LANES*32-1:0] result_in;
  logic [NUM_CORES-1:0]          has_fflags_in;
  logic [NUM_CORES*LANES*5-1:0]  fflags_in;

  logic                          valid_out;
  logic                          ready_out;
  logic [TAGW-1:0]               tag_out;
  logic [LANES*32-1:0]           result_out;
  logic                          has_fflags_out;
  logic [LANES*5-1:0]            fflags_out;
  logic [CW-1:0]                 core_out;

  modport slave (
    input  valid_in, tag_in, result_in, has_fflags_in, fflags_in, ready_out,
    output ready_in, valid_out, tag_out, result_out, has_fflags_out, fflags_out, core_out
  );

  modport master (
    output valid_in, tag_in, result_in, has_fflags_in, fflags_in, ready_out,
    input  ready_in, valid_out, tag_out, result_out, has_fflags_out, fflags_out, core_out
  );
endinterface

// File: rtl/fp_rsp_collector.sv
// Round-robin merge of NUM_CORES fixed-latency FP core responses into one
// writeback stream through a 2-entry FIFO.
module fp_rsp_collector #(
  parameter int NUM_CORES = 4,
  parameter int TAGW      = 1,
  parameter int LANES     = 1
) (
  input  logic clk,
  input  logic reset,
  fp_rsp_collector_if.slave bus
);
  localparam int CW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam int RW = LANES * 32;
  localparam int FW = LANES * 5;

  logic [CW-1:0]   rr_ptr;
  logic [CW-1:0]   grant;
  logic [CW-1:0]   idx;
  logic            found;
  int              probe;
  logic            grant_valid;
  logic            push;
  logic            pop;

  logic            head;
  logic            tail;
  logic [1:0]      count;

  logic [TAGW-1:0] tag_q  [2];
  logic [RW-1:0]   res_q  [2];
  logic [1:0]      hf_q;
  logic [FW-1:0]   ff_q   [2];
  logic [CW-1:0]   core_q [2];

  logic [TAGW-1:0] tag_sel;
  logic [RW-1:0]   res_sel;
  logic            hf_sel;
  logic [FW-1:0]   ff_sel;

  // Scan from rr_ptr with explicit wrap so non-power-of-2 core counts never index past the end.
  always_comb begin
    grant = '0;
    found = 1'b0;
    probe = 0;
    idx   = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      probe = int'(rr_ptr) + i;
      if (probe >= NUM_CORES) probe = probe - NUM_CORES;
      idx = CW'(probe);
      if (!found && bus.valid_in[idx]) begin
        found = 1'b1;
        grant = idx;
      end
    end
  end

  assign grant_valid = |bus.valid_in;
  assign push        = grant_valid && (count != 2'd2);
  assign pop         = (count != 2'd0) && bus.ready_out;

  always_comb begin
    bus.ready_in = '0;
    if (push) bus.ready_in[grant] = 1'b1;
  end

  assign tag_sel = bus.tag_in[int'(grant)*TAGW +: TAGW];
  assign res_sel = bus.result_in[int'(grant)*RW +: RW];
  assign hf_sel  = bus.has_fflags_in[grant];
  assign ff_sel  = hf_sel ? bus.fflags_in[int'(grant)*FW +: FW] : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr <= '0;
      head   <= 1'b0;
      tail   <= 1'b0;
      count  <= 2'd0;
      hf_q   <= '0;
      for (int i = 0; i < 2; i++) begin
        tag_q[i]  <= '0;
        res_q[i]  <= '0;
        ff_q[i]   <= '0;
        core_q[i] <= '0;
      end
    end else begin
      if (push) begin
        tag_q[tail]  <= tag_sel;
        res_q[tail]  <= res_sel;
        hf_q[tail]   <= hf_sel;
        ff_q[tail]   <= ff_sel;
        core_q[tail] <= grant;
        tail         <= ~tail;
        rr_ptr       <= (grant == CW'(NUM_CORES - 1)) ? '0 : grant + CW'(1);
      end
      if (pop) head <= ~head;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign bus.valid_out      = (count != 2'd0);
  assign bus.tag_out        = tag_q[head];
  assign bus.result_out     = res_q[head];
  assign bus.has_fflags_out = hf_q[head];
  assign bus.fflags_out     = ff_q[head];
  assign bus.core_out       = core_q[head];
endmodule

// File: tb/tb_fp_rsp_collector.sv
// Self-checking bench: 4-core instance driven from a vector table with a
// scoreboard of accepted responses, plus a 3-core round-robin sequence.
module tb_fp_rsp_collector;
  typedef struct {
    logic [3:0]  valid;
    logic        ro;
    logic [2:0]  tag;
    logic [31:0] res;
    logic        hf;
    logic [4:0]  ff;
    logic [3:0]  exp_ready;
  } vec_t;

  typedef struct {
    logic [2:0]  tag;
    logic [31:0] res;
    logic        hf;
    logic [4:0]  ff;
    logic [1:0]  core;
  } rsp_t;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   passed = 0;
  rsp_t sb[$];
  vec_t vecs[17];
  vec_t tmp;

  fp_rsp_collector_if #(.NUM_CORES(4), .TAGW(3), .LANES(1)) bus4 ();
  fp_rsp_collector_if #(.NUM_CORES(3), .TAGW(1), .LANES(1)) bus3 ();

  fp_rsp_collector #(.NUM_CORES(4), .TAGW(3), .LANES(1)) dut4 (
    .clk(clk), .reset(reset), .bus(bus4)
  );
  fp_rsp_collector #(.NUM_CORES(3), .TAGW(1), .LANES(1)) dut3 (
    .clk(clk), .reset(reset), .bus(bus3)
  );

  always #5 clk = ~clk;

  task check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) $display("[TB] FAIL %s: got %0h expected %0h", name, got, exp);
    else passed++;
  endtask

  task applyStimulus(input vec_t v);
    logic [2:0] cc;
    bus4.valid_in  = v.valid;
    bus4.ready_out = v.ro;
    for (int c = 0; c < 4; c++) begin
      cc = 3'(c);
      bus4.tag_in[c*3 +: 3]     = v.tag ^ cc;
      bus4.result_in[c*32 +: 32] = v.res ^ 32'(c);
      bus4.has_fflags_in[c]     = v.hf;
      bus4.fflags_in[c*5 +: 5]  = v.ff;
    end
  endtask

  // Compares against the scoreboard head, then records whatever the vector says gets accepted.
  task checkOutput(input vec_t v, input int row);
    rsp_t e;
    check($sformatf("ready_in[%0d]", row), 64'(bus4.ready_in), 64'(v.exp_ready));
    check($sformatf("valid_out[%0d]", row), 64'(bus4.valid_out), 64'(sb.size() != 0));
    if (sb.size() != 0) begin
      check($sformatf("tag_out[%0d]", row), 64'(bus4.tag_out), 64'(sb[0].tag));
      check($sformatf("result_out[%0d]", row), 64'(bus4.result_out), 64'(sb[0].res));
      check($sformatf("has_fflags_out[%0d]", row), 64'(bus4.has_fflags_out), 64'(sb[0].hf));
      check($sformatf("fflags_out[%0d]", row), 64'(bus4.fflags_out), 64'(sb[0].ff));
      check($sformatf("core_out[%0d]", row), 64'(bus4.core_out), 64'(sb[0].core));
      if (v.ro) void'(sb.pop_front());
    end
    for (int k = 0; k < 4; k++) begin
      if (v.exp_ready[k]) begin
        e.tag  = v.tag ^ 3'(k);
        e.res  = v.res ^ 32'(k);
        e.hf   = v.hf;
        e.ff   = v.hf ? v.ff : 5'd0;
        e.core = 2'(k);
        sb.push_back(e);
      end
    end
  endtask

  initial begin
    vecs[0]  = '{4'b0000, 1'b1, 3'd0, 32'h0,        1'b0, 5'b00000, 4'b0000};
    vecs[1]  = '{4'b0001, 1'b1, 3'd5, 32'h3f800000, 1'b0, 5'b11111, 4'b0001};
    vecs[2]  = '{4'b0000, 1'b1, 3'd0, 32'h0,        1'b0, 5'b00000, 4'b0000};
    vecs[3]  = '{4'b1111, 1'b1, 3'd1, 32'h40000000, 1'b1, 5'b00001, 4'b0010};
    vecs[4]  = '{4'b1111, 1'b1, 3'd2, 32'h40400000, 1'b1, 5'b10100, 4'b0100};
    vecs[5]  = '{4'b1111, 1'b1, 3'd3, 32'h40800000, 1'b0, 5'b01010, 4'b1000};
    vecs[6]  = '{4'b1111, 1'b1, 3'd4, 32'h40a00000, 1'b1, 5'b00001, 4'b0001};
    vecs[7]  = '{4'b0000, 1'b1, 3'd0, 32'h0,        1'b0, 5'b00000, 4'b0000};
    vecs[8]  = '{4'b0110, 1'b0, 3'd6, 32'hc0000000, 1'b1, 5'b10000, 4'b0010};
    vecs[9]  = '{4'b0110, 1'b0, 3'd7, 32'hc0400000, 1'b1, 5'b01000, 4'b0100};
    vecs[10] = '{4'b0110, 1'b0, 3'd1, 32'h11111111, 1'b1, 5'b00100, 4'b0000};
    vecs[11] = '{4'b0110, 1'b0, 3'd2, 32'h22222222, 1'b1, 5'b00010, 4'b0000};
    vecs[12] = '{4'b0110, 1'b1, 3'd3, 32'h33333333, 1'b1, 5'b00011, 4'b0000};
    vecs[13] = '{4'b0110, 1'b1, 3'd4, 32'h44444444, 1'b1, 5'b11000, 4'b0010};
    vecs[14] = '{4'b0000, 1'b1, 3'd0, 32'h0,        1'b0, 5'b00000, 4'b0000};
    vecs[15] = '{4'b0011, 1'b0, 3'd5, 32'h55555555, 1'b1, 5'b10101, 4'b0001};
    vecs[16] = '{4'b0011, 1'b0, 3'd6, 32'h66666666, 1'b0, 5'b11111, 4'b0010};

    reset = 1'b1;
    applyStimulus(vecs[0]);
    bus3.valid_in = '0; bus3.ready_out = 1'b1; bus3.tag_in = '0;
    bus3.result_in = '0; bus3.has_fflags_in = '0; bus3.fflags_in = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("reset valid_out", 64'(bus4.valid_out), 64'd0);
    check("reset ready_in", 64'(bus4.ready_in), 64'd0);
    check("reset result_out", 64'(bus4.result_out), 64'd0);
    check("reset core_out", 64'(bus4.core_out), 64'd0);

    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      applyStimulus(vecs[i]);
      #1;
      checkOutput(vecs[i], i);
    end

    // Reset while full, with cores still valid: nothing stale may come out and rr_ptr restarts at 0.
    @(negedge clk);
    reset = 1'b1;
    tmp = '{4'b0110, 1'b0, 3'd0, 32'h0, 1'b0, 5'b0, 4'b0000};
    applyStimulus(tmp);
    @(negedge clk);
    reset = 1'b0;
    sb.delete();
    #1;
    check("post-reset tag_out", 64'(bus4.tag_out), 64'd0);
    check("post-reset core_out", 64'(bus4.core_out), 64'd0);
    tmp = '{4'b0110, 1'b1, 3'd2, 32'h77777777, 1'b1, 5'b00110, 4'b0010};
    applyStimulus(tmp);
    checkOutput(tmp, 100);
    tmp = '{4'b0000, 1'b1, 3'd0, 32'h0, 1'b0, 5'b0, 4'b0000};
    @(negedge clk); applyStimulus(tmp); #1; checkOutput(tmp, 101);
    @(negedge clk); applyStimulus(tmp); #1; checkOutput(tmp, 102);

    // Three cores, 0 and 2 always valid: grants alternate and wrap without touching index 3.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      bus3.valid_in = 3'b101;
      for (int c = 0; c < 3; c++) bus3.result_in[c*32 +: 32] = 32'(i*16 + c);
      #1;
      check($sformatf("nc3 ready_in[%0d]", i), 64'(bus3.ready_in), (i % 2 == 0) ? 64'b001 : 64'b100);
      if (i > 0) begin
        check($sformatf("nc3 valid_out[%0d]", i), 64'(bus3.valid_out), 64'd1);
        check($sformatf("nc3 core_out[%0d]", i), 64'(bus3.core_out), (i % 2 == 1) ? 64'd0 : 64'd2);
        check($sformatf("nc3 result_out[%0d]", i), 64'(bus3.result_out),
              64'((i - 1) * 16 + ((i % 2 == 1) ? 0 : 2)));
      end
    end
    @(negedge clk);
    bus3.valid_in = '0;
    #1;
    check("nc3 last core_out", 64'(bus3.core_out), 64'd2);
    @(negedge clk);
    #1;
    check("nc3 drained", 64'(bus3.valid_out), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
